// File: rtl/aib_tx_arb_if.sv
// Requester and adapter TX handshake bundle for aib_tx_arbiter.
// slave  : the arbiter's view (consumes requester beats, produces TX beats).
// master : the surroundings' view (requesters drive beats, adapter drives ready).
interface aib_tx_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 72
);
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        i_req_last;
    logic                      o_tx_valid;
    logic                      i_tx_ready;
    logic [DATA_W-1:0]         o_tx_data;

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_valid, o_tx_data
    );

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_valid, o_tx_data
    );
endinterface

// File: rtl/aib_tx_arbiter.sv
// Round-robin packet arbiter sharing one AIB adapter TX core-side port.
// Grants are held for whole packets (delimited by last); fairness rotates at
// packet boundaries. Optional macro AIB_TX_ARB_OUTREG_EN inserts a 2-entry
// output skid buffer (registered outputs, +1 cycle latency).
//
// Handshake: a beat moves across any valid/ready pair in the cycle where both
// are high; a source holds valid/data/last stable until the beat is taken, and
// valid never waits on ready.
module aib_tx_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 72,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic               i_aib_clk,
    input  logic               i_rst_n,
    input  logic               i_arb_en,
    aib_tx_arb_if.slave        bus,
    output logic [IDW-1:0]     o_grant_id,
    output logic               o_busy
);
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    lock_q, lock_d;
    logic [IDW-1:0]    sel;
    logic [IDW-1:0]    grant;
    logic              arb_valid;
    logic              up_ready;
    logic              acc;
    logic [DATA_W-1:0] grant_data;
    logic [NUM_REQ-1:0] req_ready;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] x);
        return IDW'((int'(x) + 1) % NUM_REQ);
    endfunction

    // First valid requester scanning upward from rr_q; falls back to rr_q.
    always_comb begin
        logic             found;
        logic [IDW-1:0]   cand;
        sel   = rr_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_q) + k) % NUM_REQ);
            if (!found && bus.i_req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Owner of the port this cycle, its beat and whether it may be passed on.
    always_comb begin
        grant      = (state_q == ST_LOCKED) ? lock_q : sel;
        arb_valid  = bus.i_req_valid[grant] && ((state_q == ST_LOCKED) || i_arb_en);
        grant_data = bus.i_req_data[int'(grant)*DATA_W +: DATA_W];
        acc        = arb_valid && up_ready;
        req_ready  = '0;
        if (acc) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign bus.o_req_ready = req_ready;
    assign o_grant_id      = grant;
    assign o_busy          = (state_q == ST_LOCKED);

    // Next-state: lock on a non-final beat, rotate pointer after a final beat.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        lock_d  = lock_q;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (bus.i_req_last[grant]) begin
                        rr_d = next_id(grant);
                    end else begin
                        state_d = ST_LOCKED;
                        lock_d  = grant;
                    end
                end
            end
            ST_LOCKED: begin
                if (acc && bus.i_req_last[grant]) begin
                    state_d = ST_IDLE;
                    rr_d    = next_id(lock_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

`ifdef AIB_TX_ARB_OUTREG_EN
    logic [DATA_W-1:0] skid_q [2];
    logic              wr_q;
    logic              rd_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              full_q;
    logic              pop;

    // Requesters only see space that is already registered, so i_tx_ready
    // never reaches o_req_ready combinationally.
    always_comb begin
        up_ready = !full_q;
        pop      = (cnt_q != 2'd0) && bus.i_tx_ready;
        cnt_d    = cnt_q + {1'b0, acc} - {1'b0, pop};
    end

    // Skid buffer storage, pointers and occupancy.
    always_ff @(posedge i_aib_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_q[0] <= '0;
            skid_q[1] <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
            full_q    <= 1'b0;
        end else begin
            if (acc) begin
                skid_q[wr_q] <= grant_data;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == 2'd2);
        end
    end

    assign bus.o_tx_valid = (cnt_q != 2'd0);
    assign bus.o_tx_data  = skid_q[rd_q];
`else
    // Zero-latency passthrough; valid is independent of the adapter's ready.
    always_comb begin
        up_ready = bus.i_tx_ready;
    end

    assign bus.o_tx_valid = arb_valid;
    assign bus.o_tx_data  = grant_data;
`endif

endmodule

// File: tb/tb_aib_tx_arbiter.sv
// Directed bench for aib_tx_arbiter (default passthrough build, NUM_REQ=4).
module tb_aib_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 72;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arb_en = 1'b0;
    logic [1:0] grant_id;
    logic busy;

    aib_tx_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    aib_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .i_aib_clk  (clk),
        .i_rst_n    (rst_n),
        .i_arb_en   (arb_en),
        .bus        (bus),
        .o_grant_id (grant_id),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           en;
        logic [3:0]     valid;
        logic [3:0]     last;
        logic           tr;
        logic [3:0][7:0] d;
        logic           tv;
        logic [7:0]     dat;
        logic [3:0]     rdy;
        logic [1:0]     gid;
        logic           bsy;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic en, input logic [3:0] valid, input logic [3:0] last,
                       input logic tr, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input logic tv,
                       input logic [7:0] dat, input logic [3:0] rdy, input logic [1:0] gid,
                       input logic bsy);
        vec_t v;
        v.en = en; v.valid = valid; v.last = last; v.tr = tr;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.tv = tv; v.dat = dat; v.rdy = rdy; v.gid = gid; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic [3:0] valid, input logic [3:0] last,
                         input logic tr, input logic [3:0][7:0] d);
        arb_en          = en;
        bus.i_req_valid = valid;
        bus.i_req_last  = last;
        bus.i_tx_ready  = tr;
        for (int r = 0; r < NR; r++) begin
            bus.i_req_data[r*DW +: DW] = 72'(d[r]);
        end
    endtask

    task automatic cmp(input string tag, input string what, input logic [71:0] act,
                       input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %0h, want %0h", tag, what, act, exp);
        end
    endtask

    task automatic check(input string tag, input logic tv, input logic [7:0] dat,
                         input logic [3:0] rdy, input logic [1:0] gid, input logic bsy);
        cmp(tag, "o_tx_valid", 72'(bus.o_tx_valid), 72'(tv));
        if (tv) begin
            cmp(tag, "o_tx_data", bus.o_tx_data, 72'(dat));
        end
        cmp(tag, "o_req_ready", 72'(bus.o_req_ready), 72'(rdy));
        cmp(tag, "o_grant_id", 72'(grant_id), 72'(gid));
        cmp(tag, "o_busy", 72'(busy), 72'(bsy));
    endtask

    initial begin
        logic [3:0][7:0] dz;
        logic [3:0][7:0] dv;
        dz = '0;

        // Single requester: req1 3-beat packet; afterwards selection rests at 2.
        add(1, 4'b0010, 4'b0000, 1, 8'h00, 8'hA1, 8'h00, 8'h00, 1, 8'hA1, 4'b0010, 2'd1, 0);
        add(1, 4'b0010, 4'b0000, 1, 8'h00, 8'hA2, 8'h00, 8'h00, 1, 8'hA2, 4'b0010, 2'd1, 1);
        add(1, 4'b0010, 4'b0010, 1, 8'h00, 8'hA3, 8'h00, 8'h00, 1, 8'hA3, 4'b0010, 2'd1, 1);
        add(1, 4'b0000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 2'd2, 0);
        // Fairness: all four stream 1-beat packets, rotation 2,3,0,1,2 with no gaps.
        add(1, 4'b1111, 4'b1111, 1, 8'h00, 8'h01, 8'h02, 8'h03, 1, 8'h02, 4'b0100, 2'd2, 0);
        add(1, 4'b1111, 4'b1111, 1, 8'h00, 8'h01, 8'h02, 8'h03, 1, 8'h03, 4'b1000, 2'd3, 0);
        add(1, 4'b1111, 4'b1111, 1, 8'h00, 8'h01, 8'h02, 8'h03, 1, 8'h00, 4'b0001, 2'd0, 0);
        add(1, 4'b1111, 4'b1111, 1, 8'h00, 8'h01, 8'h02, 8'h03, 1, 8'h01, 4'b0010, 2'd1, 0);
        add(1, 4'b1111, 4'b1111, 1, 8'h00, 8'h01, 8'h02, 8'h03, 1, 8'h02, 4'b0100, 2'd2, 0);
        // Lock hold: req0 4 beats with a 2-cycle gap; req2 waits, then follows at once.
        add(1, 4'b0001, 4'b0000, 1, 8'h10, 8'h00, 8'h00, 8'h00, 1, 8'h10, 4'b0001, 2'd0, 0);
        add(1, 4'b0101, 4'b0100, 1, 8'h11, 8'h00, 8'h20, 8'h00, 1, 8'h11, 4'b0001, 2'd0, 1);
        add(1, 4'b0100, 4'b0100, 1, 8'h00, 8'h00, 8'h20, 8'h00, 0, 8'h00, 4'b0000, 2'd0, 1);
        add(1, 4'b0100, 4'b0100, 1, 8'h00, 8'h00, 8'h20, 8'h00, 0, 8'h00, 4'b0000, 2'd0, 1);
        add(1, 4'b0101, 4'b0100, 1, 8'h12, 8'h00, 8'h20, 8'h00, 1, 8'h12, 4'b0001, 2'd0, 1);
        add(1, 4'b0101, 4'b0101, 1, 8'h13, 8'h00, 8'h20, 8'h00, 1, 8'h13, 4'b0001, 2'd0, 1);
        add(1, 4'b0100, 4'b0100, 1, 8'h00, 8'h00, 8'h20, 8'h00, 1, 8'h20, 4'b0100, 2'd2, 0);
        add(1, 4'b0000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 2'd3, 0);
        // Backpressure: req3 5 beats with adapter ready 1,0,0,1,0,0,1,1,1.
        add(1, 4'b1000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h31, 1, 8'h31, 4'b1000, 2'd3, 0);
        add(1, 4'b1000, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h32, 1, 8'h32, 4'b0000, 2'd3, 1);
        add(1, 4'b1000, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h32, 1, 8'h32, 4'b0000, 2'd3, 1);
        add(1, 4'b1000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h32, 1, 8'h32, 4'b1000, 2'd3, 1);
        add(1, 4'b1000, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h33, 1, 8'h33, 4'b0000, 2'd3, 1);
        add(1, 4'b1000, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h33, 1, 8'h33, 4'b0000, 2'd3, 1);
        add(1, 4'b1000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h33, 1, 8'h33, 4'b1000, 2'd3, 1);
        add(1, 4'b1000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h34, 1, 8'h34, 4'b1000, 2'd3, 1);
        add(1, 4'b1000, 4'b1000, 1, 8'h00, 8'h00, 8'h00, 8'h35, 1, 8'h35, 4'b1000, 2'd3, 1);
        add(1, 4'b0000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 2'd0, 0);
        // Enable gating: req3 finishes with enable low; req1 waits for enable.
        add(1, 4'b1000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h40, 1, 8'h40, 4'b1000, 2'd3, 0);
        add(0, 4'b1010, 4'b0010, 1, 8'h00, 8'h50, 8'h00, 8'h41, 1, 8'h41, 4'b1000, 2'd3, 1);
        add(0, 4'b1010, 4'b1010, 1, 8'h00, 8'h50, 8'h00, 8'h42, 1, 8'h42, 4'b1000, 2'd3, 1);
        add(0, 4'b0010, 4'b0010, 1, 8'h00, 8'h50, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 2'd1, 0);
        add(0, 4'b0010, 4'b0010, 1, 8'h00, 8'h50, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 2'd1, 0);
        add(1, 4'b0010, 4'b0010, 1, 8'h00, 8'h50, 8'h00, 8'h00, 1, 8'h50, 4'b0010, 2'd1, 0);
        add(1, 4'b0000, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 4'b0000, 2'd2, 0);

        // Reset state.
        drive(0, 4'b0000, 4'b0000, 0, dz);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset", 0, 8'h00, 4'b0000, 2'd0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].valid, vecs[i].last, vecs[i].tr, vecs[i].d);
            #1;
            check($sformatf("vec%0d", i), vecs[i].tv, vecs[i].dat, vecs[i].rdy,
                  vecs[i].gid, vecs[i].bsy);
        end

        // Reset during beat 2 of a 3-beat packet from req0.
        dv = '0;
        dv[0] = 8'h60;
        @(negedge clk);
        drive(1, 4'b0001, 4'b0000, 1, dv);
        #1;
        check("rst_beat1", 1, 8'h60, 4'b0001, 2'd0, 0);
        dv[0] = 8'h61;
        @(negedge clk);
        drive(1, 4'b0001, 4'b0000, 1, dv);
        #1;
        check("rst_beat2", 1, 8'h61, 4'b0001, 2'd0, 1);
        #1;
        rst_n = 1'b0;
        drive(1, 4'b0000, 4'b0000, 1, dz);
        #1;
        check("rst_mid", 0, 8'h00, 4'b0000, 2'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release", 0, 8'h00, 4'b0000, 2'd0, 0);
        dv = '0;
        dv[2] = 8'h70;
        @(negedge clk);
        drive(1, 4'b0100, 4'b0100, 1, dv);
        #1;
        check("rst_req2", 1, 8'h70, 4'b0100, 2'd2, 0);
        @(negedge clk);
        drive(1, 4'b0000, 4'b0000, 1, dz);
        #1;
        check("rst_after", 0, 8'h00, 4'b0000, 2'd3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
